// File: rtl/pwm_cfg_sequencer.sv
// Round-robin arbitrated sequencer that writes PWM_CFG0/PWM_CFG1 and arms PWM_CTRL.ld_trg.
// Optional build macro PWM_SEQ_TMO_EN adds a saturating timeout on the ld_trg wait.

module pwm_cfg_sequencer #(
    parameter int DATA_WIDTH = 32,
    parameter int N          = 16,
    parameter int NUM_REQ    = 4,
    parameter int TMO_W      = 20
) (
    input  logic                    sys_clk,
    input  logic                    sys_rst_n,
    input  logic [NUM_REQ-1:0]      req,
    input  logic [NUM_REQ*N-1:0]    req_pr,
    input  logic [NUM_REQ*N-1:0]    req_dc,
    input  logic [NUM_REQ*N-1:0]    req_ph,
    input  logic [NUM_REQ*N-1:0]    req_of,
    output logic [NUM_REQ-1:0]      ack,
    output logic [NUM_REQ-1:0]      err,
    input  logic                    pwm_on,
    input  logic                    ld_trg_stat,
    output logic                    cfg0_we,
    output logic                    cfg1_we,
    output logic [DATA_WIDTH-1:0]   cfg_wdata,
    output logic                    ld_trg_set,
    output logic                    busy
);

    localparam int             PW       = $clog2(NUM_REQ);
    localparam logic [PW-1:0]  LAST_IDX = PW'(NUM_REQ - 1);
    localparam logic [PW-1:0]  ONE_P    = PW'(1);

    if ((2 * N > DATA_WIDTH) || (NUM_REQ < 2) || (NUM_REQ > 8) || (TMO_W < 2)) begin : g_bad_params
        $error("pwm_cfg_sequencer: unsupported parameter combination");
    end

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CHECK = 3'd1,
        ST_WR0   = 3'd2,
        ST_WR1   = 3'd3,
        ST_ARM   = 3'd4,
        ST_WAIT  = 3'd5,
        ST_DONE  = 3'd6
    } state_t;

    state_t               state_r;
    state_t               state_nxt_s;
    logic [PW-1:0]        rr_ptr_r;
    logic [PW-1:0]        gnt_r;
    logic [PW-1:0]        pick_s;
    logic                 req_any_s;
    logic                 err_nxt_s;
    logic                 wait_first_r;
    logic                 tmo_hit_s;
    logic [NUM_REQ-1:0]   gnt_oh_s;
    logic [N-1:0]         pr_r;
    logic [N-1:0]         dc_r;
    logic [N-1:0]         ph_r;
    logic [N-1:0]         of_r;

`ifdef PWM_SEQ_TMO_EN
    localparam logic [TMO_W-1:0] TMO_MAX  = {TMO_W{1'b1}};
    localparam logic [TMO_W-1:0] TMO_ONE  = TMO_W'(1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_MAX - TMO_ONE;

    logic [TMO_W-1:0] tmo_cnt_r;

    // Timeout counter: cleared while arming, counts WAIT cycles, saturates at all-ones
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            tmo_cnt_r <= {TMO_W{1'b0}};
        end else if (state_r == ST_ARM) begin
            tmo_cnt_r <= {TMO_W{1'b0}};
        end else if ((state_r == ST_WAIT) && (tmo_cnt_r != TMO_MAX)) begin
            tmo_cnt_r <= tmo_cnt_r + TMO_ONE;
        end else begin
            tmo_cnt_r <= tmo_cnt_r;
        end
    end

    // The counter reaches all-ones at the end of this WAIT cycle
    assign tmo_hit_s = (tmo_cnt_r == TMO_LAST);
`else
    assign tmo_hit_s = 1'b0;
`endif

    // Round-robin pick: first requester at or after the pointer; loop runs backwards so the nearest wins
    always_comb begin
        int idx;
        idx       = 0;
        req_any_s = 1'b0;
        pick_s    = {PW{1'b0}};
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            idx       = (int'(rr_ptr_r) + i) % NUM_REQ;
            req_any_s = req_any_s | req[idx];
            pick_s    = req[idx] ? PW'(idx) : pick_s;
        end
    end

    // One-hot of the latched grant, used for ack/err
    always_comb begin
        gnt_oh_s        = {NUM_REQ{1'b0}};
        gnt_oh_s[gnt_r] = 1'b1;
    end

    // Next-state logic; err_nxt_s only matters on transitions into DONE
    always_comb begin
        state_nxt_s = state_r;
        err_nxt_s   = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (req_any_s) begin
                    state_nxt_s = ST_CHECK;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_CHECK: begin
                if ((dc_r > pr_r) || (ph_r > pr_r) || (of_r > pr_r) || !pwm_on) begin
                    state_nxt_s = ST_DONE;
                    err_nxt_s   = 1'b1;
                end else begin
                    state_nxt_s = ST_WR0;
                end
            end
            ST_WR0:  state_nxt_s = ST_WR1;
            ST_WR1:  state_nxt_s = ST_ARM;
            ST_ARM:  state_nxt_s = ST_WAIT;
            ST_WAIT: begin
                // ld_trg_stat is stale in the first WAIT cycle; a PWM switch-off aborts at any time
                if (!pwm_on) begin
                    state_nxt_s = ST_DONE;
                    err_nxt_s   = 1'b1;
                end else if (wait_first_r) begin
                    state_nxt_s = ST_WAIT;
                end else if (!ld_trg_stat) begin
                    state_nxt_s = ST_DONE;
                end else if (tmo_hit_s) begin
                    state_nxt_s = ST_DONE;
                    err_nxt_s   = 1'b1;
                end else begin
                    state_nxt_s = ST_WAIT;
                end
            end
            ST_DONE: state_nxt_s = ST_IDLE;
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // State, round-robin pointer, grant and the latched configuration set
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_r      <= ST_IDLE;
            rr_ptr_r     <= {PW{1'b0}};
            gnt_r        <= {PW{1'b0}};
            wait_first_r <= 1'b0;
            pr_r         <= {N{1'b0}};
            dc_r         <= {N{1'b0}};
            ph_r         <= {N{1'b0}};
            of_r         <= {N{1'b0}};
        end else begin
            state_r      <= state_nxt_s;
            wait_first_r <= (state_r == ST_ARM);
            if ((state_r == ST_IDLE) && req_any_s) begin
                gnt_r    <= pick_s;
                rr_ptr_r <= (pick_s == LAST_IDX) ? {PW{1'b0}} : (pick_s + ONE_P);
                pr_r     <= req_pr[pick_s*N +: N];
                dc_r     <= req_dc[pick_s*N +: N];
                ph_r     <= req_ph[pick_s*N +: N];
                of_r     <= req_of[pick_s*N +: N];
            end else begin
                gnt_r    <= gnt_r;
                rr_ptr_r <= rr_ptr_r;
                pr_r     <= pr_r;
                dc_r     <= dc_r;
                ph_r     <= ph_r;
                of_r     <= of_r;
            end
        end
    end

    // Registered outputs decoded from the state being entered
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            cfg0_we    <= 1'b0;
            cfg1_we    <= 1'b0;
            ld_trg_set <= 1'b0;
            busy       <= 1'b0;
            cfg_wdata  <= {DATA_WIDTH{1'b0}};
            ack        <= {NUM_REQ{1'b0}};
            err        <= {NUM_REQ{1'b0}};
        end else begin
            cfg0_we    <= (state_nxt_s == ST_WR0);
            cfg1_we    <= (state_nxt_s == ST_WR1);
            ld_trg_set <= (state_nxt_s == ST_ARM);
            busy       <= (state_nxt_s != ST_IDLE);
            case (state_nxt_s)
                ST_WR0:  cfg_wdata <= DATA_WIDTH'({dc_r, pr_r});
                ST_WR1:  cfg_wdata <= DATA_WIDTH'({of_r, ph_r});
                default: cfg_wdata <= {DATA_WIDTH{1'b0}};
            endcase
            ack <= (state_nxt_s == ST_DONE) ? gnt_oh_s : {NUM_REQ{1'b0}};
            err <= ((state_nxt_s == ST_DONE) && err_nxt_s) ? gnt_oh_s : {NUM_REQ{1'b0}};
        end
    end

endmodule
